cal_alarm_clock: RTL and testbench
==================================

# cal_alarm_clock

Parametrised calendar clock with a multi-alarm bank. It keeps seconds, minutes, hours, weekday, date, month and a leap-year phase, with month-length and date clamping. It has NA independently settable alarms, each with a day-of-week or every-day match, a timed ring and snooze. It sits between the 1 Hz Pulse domain and the display/buzzer drivers and exports binary time fields; 7-segment decoding stays outside.

## Interface
- NS, 60: seconds/minute and minutes/hour modulus
- NH, 24: hours/day modulus
- ND, 7: weekdays; alarm day value ND means every day
- NA, 4: number of alarms (≥1)
- RING, 60: ring duration in Pulse cycles
- SNOOZE, 5: snooze length in minutes (SNOOZE*NS cycles)
- LEAP_EN, 1: 1 = Feb has 29 days when TYear==0; 0 = always 28

- Pulse  in  1  clock, one cycle per second
- Reset  in  1  synchronous, active-high
- Timeset  in  1  time-set mode
- Alarmset  in  1  alarm-set mode
- Alarmsel  in  $clog2(NA) (min 1)  alarm selected for setting/readback
- Minadv, Hrsadv, Dayadv, Datadv, Monadv, Yradv  in  1 each  field advance buttons
- Alarmon  in  NA  per-alarm arm
- Snooze  in  1  snooze request, level-sampled
- TSec, TMin, THrs, TDays, TDate, TMonth  out  7 each  time fields, 0-based
- TYear  out  2  year mod 4, 0 = leap year
- AMin, AHrs, ADays  out  7 each  fields of alarm[Alarmsel]
- Hit  out  NA  alarm i ringing
- Buzz  out  1  OR of Hit

## Operation
- Reset: all time fields and TYear = 0. Every alarm = 0 min, 0 hrs, ADays = ND. Every alarm state = IDLE, ring/snooze counters = 0, Hit = 0, Buzz = 0.
- Run (Timeset=0): TSec increments mod NS each cycle.
  - S_max = (TSec==NS-1) advances TMin.
  - S_max & TMin==NS-1 advances THrs.
  - Day rollover (23:59:59) advances TDays mod ND and TDate.
  - TDate==len-1 at rollover: TDate=0, TMonth increments mod 12.
  - TMonth==11 wrap also increments TYear mod 4.
- len(month, year):
  - 31 for months 0, 2, 4, 6, 7, 9, 11.
  - Month 1: 29 if LEAP_EN && TYear==0, else 28.
  - All other months: 30.
- Timeset=1: TSec holds. Each adv button increments its field by 1 per cycle with no carry into other fields.
  - Minadv: TMin mod NS. Hrsadv: THrs mod NH. Dayadv: TDays mod ND.
  - Datadv: TDate mod len(current month, year).
  - Monadv: TMonth mod 12. Yradv: TYear mod 4.
  - Multiple buttons may be active together; each acts independently.
- Date clamp: on any edge where TMonth or TYear changes, next TDate = min(next TDate, len(next month, next year)-1).
- Alarmset=1 and Timeset=0: time keeps running.
  - Minadv, Hrsadv, Dayadv advance alarm[Alarmsel] fields; ADays is mod ND+1.
  - Datadv, Monadv and Yradv are ignored.
- Timeset=1 and Alarmset=1: Timeset wins; all alarm registers hold.
- Trigger i = Alarmon[i] & Timeset==0 & TSec==0 & TMin==AMin_i & THrs==AHrs_i & (ADays_i==ND | ADays_i==TDays).
- Per-alarm FSM (states IDLE, RING, SNZ). Alarmon[i]=0 forces IDLE from any state, with priority over all other transitions.
  - IDLE -> RING on trigger; ring counter loads RING-1.
  - RING: counter decrements each cycle. Snooze=1 -> SNZ with snooze counter loaded to SNOOZE*NS-1. Counter==0 with no Snooze -> IDLE.
  - SNZ: counter decrements each cycle, also while Timeset=1. At 0 -> RING with ring counter reloaded. Triggers are ignored while in SNZ.
  - Trigger while in RING: no effect, counter not reloaded.
- Hit[i] = (state_i==RING). Buzz = |Hit. Both are registered outputs.
- AMin/AHrs/ADays are a combinational mux on Alarmsel. An out-of-range Alarmsel reads alarm 0 and its writes are dropped.

## Timing
- All state updates on the rising edge of Pulse. Reset takes effect on the edge where it is sampled high and overrides every other input.
- A set-mode button held for k cycles gives exactly k increments.
- Trigger is evaluated on current register values. Hit[i] rises on the following edge (1-cycle latency from the cycle TSec shows 0).
- Ring: Hit[i] stays high exactly RING cycles.
- Snooze: Snooze sampled high in RING drops Hit[i] at that edge. Hit[i] rises again exactly SNOOZE*NS cycles later.
- Reset with Alarmon set: the first post-reset cycle has TSec=0 and the default 00:00 every-day alarm matches. Hit rises one edge after Reset deasserts.
- Counter widths: the ring counter is sized to RING; the snooze counter is sized to SNOOZE*NS.

## Test plan
- Day rollover: Reset, then 86400 run cycles -> TDays=1, TDate=1, all other fields 0, TYear=0.
- Leap year: TMonth=1, TDate=27, 23:59:59.
  - TYear=1, one Pulse -> TMonth=2, TDate=0.
  - TYear=0, same stimulus -> TMonth=1, TDate=28.
- Clamp: Timeset=1, TMonth=0, TDate=30, TYear=1, Monadv for one cycle -> TMonth=1, TDate=27. Same with TYear=0 -> TDate=28.
- Alarm ring: alarm 2 = 07:30 with ADays=ND, Alarmon=4'b0100, time 07:29:59 Wed.
  - Hit=4'b0100 one cycle after TSec=0; Buzz high exactly 60 cycles, then low.
  - Same run with ADays=2 and TDays=3 -> no Hit.
- Snooze: Snooze pulse on ring cycle 10 -> Hit[2] low next edge, high again 300 cycles later for 60 cycles. Dropping Alarmon[2] during SNZ -> never rings.
- Mode precedence: Alarmset=1, Alarmsel=1, Hrsadv held 3 cycles -> alarm1 AHrs=3, other alarms unchanged, TSec advanced by 3. Adding Timeset=1 -> THrs increments, alarm1 unchanged, TSec held.

Source files
------------

// File: rtl/cal_alarm_clock.sv
// cal_alarm_clock: calendar clock with leap-year month lengths and an
// NA-entry alarm bank with timed ring and snooze, clocked by the 1 Hz Pulse.
module cal_alarm_clock #(
  parameter int NS      = 60,
  parameter int NH      = 24,
  parameter int ND      = 7,
  parameter int NA      = 4,
  parameter int RING    = 60,
  parameter int SNOOZE  = 5,
  parameter int LEAP_EN = 1
) (
  input  logic                                Pulse,
  input  logic                                Reset,
  input  logic                                Timeset,
  input  logic                                Alarmset,
  input  logic [((NA>1)?$clog2(NA):1)-1:0]    Alarmsel,
  input  logic                                Minadv,
  input  logic                                Hrsadv,
  input  logic                                Dayadv,
  input  logic                                Datadv,
  input  logic                                Monadv,
  input  logic                                Yradv,
  input  logic [NA-1:0]                       Alarmon,
  input  logic                                Snooze,
  output logic [6:0]                          TSec,
  output logic [6:0]                          TMin,
  output logic [6:0]                          THrs,
  output logic [6:0]                          TDays,
  output logic [6:0]                          TDate,
  output logic [6:0]                          TMonth,
  output logic [1:0]                          TYear,
  output logic [6:0]                          AMin,
  output logic [6:0]                          AHrs,
  output logic [6:0]                          ADays,
  output logic [NA-1:0]                       Hit,
  output logic                                Buzz
);

  localparam int SW      = (NA > 1) ? $clog2(NA) : 1;
  localparam int SNZ_CYC = SNOOZE * NS;
  localparam int RW      = (RING > 1) ? $clog2(RING) : 1;
  localparam int ZW      = (SNZ_CYC > 1) ? $clog2(SNZ_CYC) : 1;

  localparam logic [6:0]    S_LAST = 7'(NS - 1);
  localparam logic [6:0]    H_LAST = 7'(NH - 1);
  localparam logic [6:0]    D_LAST = 7'(ND - 1);
  localparam logic [6:0]    A_ALL  = 7'(ND);
  localparam logic [RW-1:0] R_LOAD = RW'(RING - 1);
  localparam logic [ZW-1:0] Z_LOAD = ZW'(SNZ_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNZ} st_t;

  function automatic logic [6:0] mlen(
    input logic [6:0] m,
    input logic [1:0] y
  );
    case (m)
      7'd1:    mlen = (LEAP_EN != 0 && y == 2'd0) ? 7'd29 : 7'd28;
      7'd3, 7'd5, 7'd8, 7'd10:
               mlen = 7'd30;
      default: mlen = 7'd31;
    endcase
  endfunction

  logic       s_max, m_max, h_max, dy_max;
  logic       roll, d_last, mo_last, chg;
  logic [6:0] cur_len, new_len;
  logic [6:0] sec_n, min_n, hrs_n, day_n;
  logic [6:0] date_raw, date_n, mon_n;
  logic [1:0] yr_n;

  assign s_max   = TSec >= S_LAST;
  assign m_max   = TMin >= S_LAST;
  assign h_max   = THrs >= H_LAST;
  assign dy_max  = TDays >= D_LAST;
  assign roll    = s_max & m_max & h_max;
  assign cur_len = mlen(TMonth, TYear);
  assign d_last  = TDate >= cur_len - 7'd1;
  assign mo_last = TMonth >= 7'd11;

  always_comb begin
    sec_n    = TSec;
    min_n    = TMin;
    hrs_n    = THrs;
    day_n    = TDays;
    date_raw = TDate;
    mon_n    = TMonth;
    yr_n     = TYear;
    if (!Timeset) begin
      sec_n = s_max ? 7'd0 : TSec + 7'd1;
      if (s_max)
        min_n = m_max ? 7'd0 : TMin + 7'd1;
      if (s_max && m_max)
        hrs_n = h_max ? 7'd0 : THrs + 7'd1;
      if (roll) begin
        day_n    = dy_max ? 7'd0 : TDays + 7'd1;
        date_raw = d_last ? 7'd0 : TDate + 7'd1;
        if (d_last) begin
          mon_n = mo_last ? 7'd0 : TMonth + 7'd1;
          if (mo_last)
            yr_n = TYear + 2'd1;
        end
      end
    end else begin
      if (Minadv) min_n = m_max ? 7'd0 : TMin + 7'd1;
      if (Hrsadv) hrs_n = h_max ? 7'd0 : THrs + 7'd1;
      if (Dayadv) day_n = dy_max ? 7'd0 : TDays + 7'd1;
      if (Datadv) date_raw = d_last ? 7'd0 : TDate + 7'd1;
      if (Monadv) mon_n = mo_last ? 7'd0 : TMonth + 7'd1;
      if (Yradv)  yr_n = TYear + 2'd1;
    end
  end

  // a month/year change may shorten the month under the current date
  assign new_len = mlen(mon_n, yr_n);
  assign chg     = (mon_n != TMonth) || (yr_n != TYear);
  assign date_n  = (chg && date_raw > new_len - 7'd1) ?
                   new_len - 7'd1 : date_raw;

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      TSec   <= '0;
      TMin   <= '0;
      THrs   <= '0;
      TDays  <= '0;
      TDate  <= '0;
      TMonth <= '0;
      TYear  <= '0;
    end else begin
      TSec   <= sec_n;
      TMin   <= min_n;
      THrs   <= hrs_n;
      TDays  <= day_n;
      TDate  <= date_n;
      TMonth <= mon_n;
      TYear  <= yr_n;
    end
  end

  logic [6:0] amin  [NA];
  logic [6:0] ahrs  [NA];
  logic [6:0] adays [NA];
  logic       sel_ok, aset;

  if (NA == (1 << SW)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = Alarmsel < SW'(NA);
  end

  assign aset = Alarmset & ~Timeset & sel_ok;

  always_ff @(posedge Pulse) begin
    for (int i = 0; i < NA; i++) begin
      if (Reset) begin
        amin[i]  <= '0;
        ahrs[i]  <= '0;
        adays[i] <= A_ALL;
      end else if (aset && Alarmsel == SW'(i)) begin
        if (Minadv)
          amin[i] <= (amin[i] >= S_LAST) ? 7'd0 : amin[i] + 7'd1;
        if (Hrsadv)
          ahrs[i] <= (ahrs[i] >= H_LAST) ? 7'd0 : ahrs[i] + 7'd1;
        if (Dayadv)
          adays[i] <= (adays[i] >= A_ALL) ? 7'd0 : adays[i] + 7'd1;
      end
    end
  end

  always_comb begin
    AMin  = amin[0];
    AHrs  = ahrs[0];
    ADays = adays[0];
    for (int i = 1; i < NA; i++) begin
      if (sel_ok && Alarmsel == SW'(i)) begin
        AMin  = amin[i];
        AHrs  = ahrs[i];
        ADays = adays[i];
      end
    end
  end

  st_t           st   [NA];
  st_t           st_n [NA];
  logic [RW-1:0] rc   [NA];
  logic [RW-1:0] rc_n [NA];
  logic [ZW-1:0] zc   [NA];
  logic [ZW-1:0] zc_n [NA];
  logic [NA-1:0] trig, hit_n;

  always_comb begin
    for (int i = 0; i < NA; i++) begin
      trig[i] = Alarmon[i] & ~Timeset & (TSec == 7'd0) &
                (TMin == amin[i]) & (THrs == ahrs[i]) &
                ((adays[i] == A_ALL) | (adays[i] == TDays));
    end
  end

  always_comb begin
    for (int i = 0; i < NA; i++) begin
      st_n[i] = st[i];
      rc_n[i] = rc[i];
      zc_n[i] = zc[i];
      if (!Alarmon[i]) begin
        st_n[i] = ST_IDLE;
        rc_n[i] = '0;
        zc_n[i] = '0;
      end else begin
        unique case (st[i])
          ST_IDLE: begin
            if (trig[i]) begin
              st_n[i] = ST_RING;
              rc_n[i] = R_LOAD;
            end
          end
          ST_RING: begin
            if (Snooze) begin
              st_n[i] = ST_SNZ;
              zc_n[i] = Z_LOAD;
            end else if (rc[i] == '0) begin
              st_n[i] = ST_IDLE;
            end else begin
              rc_n[i] = rc[i] - 1'b1;
            end
          end
          ST_SNZ: begin
            if (zc[i] == '0) begin
              st_n[i] = ST_RING;
              rc_n[i] = R_LOAD;
            end else begin
              zc_n[i] = zc[i] - 1'b1;
            end
          end
          default: st_n[i] = ST_IDLE;
        endcase
      end
      hit_n[i] = (st_n[i] == ST_RING);
    end
  end

  always_ff @(posedge Pulse) begin
    if (Reset) begin
      for (int i = 0; i < NA; i++) begin
        st[i] <= ST_IDLE;
        rc[i] <= '0;
        zc[i] <= '0;
      end
      Hit  <= '0;
      Buzz <= 1'b0;
    end else begin
      for (int i = 0; i < NA; i++) begin
        st[i] <= st_n[i];
        rc[i] <= rc_n[i];
        zc[i] <= zc_n[i];
      end
      Hit  <= hit_n;
      Buzz <= |hit_n;
    end
  end

endmodule

// File: tb/tb_cal_alarm_clock.sv
// tb_cal_alarm_clock: directed checks of calendar carries, leap/clamp,
// alarm ring, snooze, forced idle and set-mode precedence.
module tb_cal_alarm_clock;

  logic       Pulse = 1'b0;
  logic       Reset = 1'b0;
  logic       Timeset = 1'b0;
  logic       Alarmset = 1'b0;
  logic [1:0] Alarmsel = 2'd0;
  logic       Minadv = 1'b0, Hrsadv = 1'b0, Dayadv = 1'b0;
  logic       Datadv = 1'b0, Monadv = 1'b0, Yradv = 1'b0;
  logic [3:0] Alarmon = 4'd0;
  logic       Snooze = 1'b0;
  logic [6:0] TSec, TMin, THrs, TDays, TDate, TMonth;
  logic [1:0] TYear;
  logic [6:0] AMin, AHrs, ADays;
  logic [3:0] Hit;
  logic       Buzz;

  int nchk = 0;
  int nfail = 0;
  int n;

  cal_alarm_clock dut (
    .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset),
    .Alarmset(Alarmset), .Alarmsel(Alarmsel),
    .Minadv(Minadv), .Hrsadv(Hrsadv), .Dayadv(Dayadv),
    .Datadv(Datadv), .Monadv(Monadv), .Yradv(Yradv),
    .Alarmon(Alarmon), .Snooze(Snooze),
    .TSec(TSec), .TMin(TMin), .THrs(THrs), .TDays(TDays),
    .TDate(TDate), .TMonth(TMonth), .TYear(TYear),
    .AMin(AMin), .AHrs(AHrs), .ADays(ADays),
    .Hit(Hit), .Buzz(Buzz)
  );

  always #5 Pulse = ~Pulse;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge Pulse);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  // hold set-mode buttons concurrently, each released at its target count
  task automatic tset(input int h, input int m, input int dy,
                      input int dt, input int mo, input int yr);
    int mx;
    mx = h;
    if (m > mx) mx = m;
    if (dy > mx) mx = dy;
    if (dt > mx) mx = dt;
    if (mo > mx) mx = mo;
    if (yr > mx) mx = yr;
    Timeset = 1'b1;
    for (int k = 0; k < mx; k++) begin
      Hrsadv = (k < h);
      Minadv = (k < m);
      Dayadv = (k < dy);
      Datadv = (k < dt);
      Monadv = (k < mo);
      Yradv  = (k < yr);
      step(1);
    end
    {Hrsadv, Minadv, Dayadv, Datadv, Monadv, Yradv} = '0;
    Timeset = 1'b0;
  endtask

  // alarm 2 = 07:30 with dp ADays presses; time ends at Wed 07:29:59
  task automatic alarm_setup(input int dp);
    Alarmon = 4'd0;
    do_reset();
    Alarmset = 1'b1;
    Alarmsel = 2'd2;
    for (int k = 0; k < 30; k++) begin
      Hrsadv = (k < 7);
      Minadv = 1'b1;
      Dayadv = (k < dp);
      step(1);
    end
    {Alarmset, Hrsadv, Minadv, Dayadv} = '0;
    tset(7, 29, 3, 0, 0, 0);
    Alarmon = 4'b0100;
    step(29);
  endtask

  initial begin
    do_reset();
    chk("rst_sec", TSec, 0);
    chk("rst_min", TMin, 0);
    chk("rst_hrs", THrs, 0);
    chk("rst_day", TDays, 0);
    chk("rst_date", TDate, 0);
    chk("rst_mon", TMonth, 0);
    chk("rst_yr", TYear, 0);
    chk("rst_amin", AMin, 0);
    chk("rst_ahrs", AHrs, 0);
    chk("rst_adays", ADays, 7);
    chk("rst_hit", Hit, 0);
    chk("rst_buzz", Buzz, 0);

    tset(23, 59, 0, 0, 0, 0);
    step(59);
    chk("pre_roll_sec", TSec, 59);
    step(1);
    chk("roll_day", TDays, 1);
    chk("roll_date", TDate, 1);
    chk("roll_sec", TSec, 0);
    chk("roll_min", TMin, 0);
    chk("roll_hrs", THrs, 0);
    chk("roll_mon", TMonth, 0);
    chk("roll_yr", TYear, 0);

    do_reset();
    tset(23, 59, 0, 27, 1, 1);
    step(60);
    chk("feb28_mon", TMonth, 2);
    chk("feb28_date", TDate, 0);
    chk("feb28_yr", TYear, 1);

    do_reset();
    tset(23, 59, 0, 27, 1, 0);
    step(60);
    chk("feb29_mon", TMonth, 1);
    chk("feb29_date", TDate, 28);

    do_reset();
    tset(0, 0, 0, 30, 0, 1);
    chk("jan31_date", TDate, 30);
    Timeset = 1'b1;
    Monadv = 1'b1;
    step(1);
    {Monadv, Timeset} = '0;
    chk("clamp_mon", TMonth, 1);
    chk("clamp_d27", TDate, 27);

    do_reset();
    tset(0, 0, 0, 30, 0, 0);
    Timeset = 1'b1;
    Monadv = 1'b1;
    step(1);
    Monadv = 1'b0;
    chk("clamp_d28", TDate, 28);
    Datadv = 1'b1;
    step(1);
    {Datadv, Timeset} = '0;
    chk("date_wrap", TDate, 0);

    alarm_setup(0);
    chk("a2_min", AMin, 30);
    chk("a2_hrs", AHrs, 7);
    chk("a2_days", ADays, 7);
    chk("t_sec", TSec, 59);
    chk("t_min", TMin, 29);
    chk("t_hrs", THrs, 7);
    chk("t_day", TDays, 3);
    step(1);
    chk("trig_cyc_hit", Hit, 0);
    step(1);
    chk("ring_hit", Hit, 4'b0100);
    n = 0;
    while (Buzz && n < 200) begin
      n++;
      step(1);
    end
    chk("ring_len", n, 60);
    chk("ring_end_hit", Hit, 0);

    alarm_setup(3);
    chk("a2_days_wed", ADays, 2);
    n = 0;
    for (int k = 0; k < 80; k++) begin
      if (Buzz) n++;
      step(1);
    end
    chk("no_day_hit", n, 0);

    alarm_setup(0);
    step(2);
    chk("snz_ring1", Hit, 4'b0100);
    step(9);
    chk("snz_ring10", Hit, 4'b0100);
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    chk("snz_drop", Hit, 0);
    n = 0;
    while (!Hit[2] && n < 400) begin
      step(1);
      n++;
    end
    chk("snz_gap", n, 300);
    n = 0;
    while (Hit[2] && n < 200) begin
      step(1);
      n++;
    end
    chk("snz_ring_len", n, 60);

    alarm_setup(0);
    step(11);
    Snooze = 1'b1;
    step(1);
    Snooze = 1'b0;
    step(5);
    Alarmon = 4'd0;
    step(1);
    Alarmon = 4'b0100;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      if (Buzz) n++;
      step(1);
    end
    chk("off_in_snz", n, 0);

    Alarmon = 4'd0;
    do_reset();
    Alarmset = 1'b1;
    Alarmsel = 2'd1;
    Hrsadv = 1'b1;
    Datadv = 1'b1;
    Monadv = 1'b1;
    step(3);
    chk("aset_ahrs", AHrs, 3);
    chk("aset_sec", TSec, 3);
    chk("aset_thrs", THrs, 0);
    chk("aset_date", TDate, 0);
    chk("aset_mon", TMonth, 0);
    Alarmsel = 2'd2;
    #1;
    chk("aset_other", AHrs, 0);
    Alarmsel = 2'd1;
    {Datadv, Monadv} = '0;
    Timeset = 1'b1;
    step(2);
    chk("tset_thrs", THrs, 2);
    chk("tset_ahrs", AHrs, 3);
    chk("tset_sec", TSec, 3);
    {Alarmset, Timeset, Hrsadv} = '0;
    Alarmsel = 2'd0;

    Alarmon = 4'b0001;
    do_reset();
    chk("rst_on_sec", TSec, 0);
    chk("rst_on_hit", Hit, 0);
    step(1);
    chk("rst_on_hit1", Hit, 4'b0001);
    chk("rst_on_buzz", Buzz, 1);
    Alarmon = 4'd0;
    step(1);
    chk("rst_off_hit", Hit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
